gshare_pht: RTL and testbench

GSHARE_PHT -- requirements
Module: gshare_pht

---
 rtl/gshare_pht_pkg.sv | 20 ++
 rtl/gshare_pht_if.sv | 25 ++
 rtl/gshare_pht_sat_ctr2.sv | 20 ++
 rtl/gshare_pht.sv | 111 +++++++++++
 tb/tb_gshare_pht.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gshare_pht_pkg.sv
// Shared types and sizing for the gshare pattern history table.
// Counters use the classic 2-bit saturating scheme; bit 1 is the predicted direction.
package gshare_pht_pkg;

    localparam int GHR_W       = 10;
    localparam int PHT_ENTRIES = 2 ** GHR_W;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } pht_ctr_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } pht_state_t;

endpackage

// File: rtl/gshare_pht_if.sv
// Prediction and training bus between the fetch/resolve stages and the gshare table.
interface gshare_pht_if #(
    parameter int GHR_W = gshare_pht_pkg::GHR_W
);
    logic             pred_valid_in;
    logic [31:0]      pred_pc;
    logic [GHR_W-1:0] history;
    logic             pred_valid_out;
    logic             pred_taken;
    logic [GHR_W-1:0] pred_index;
    logic             ready;
    logic             upd_valid;
    logic [GHR_W-1:0] upd_index;
    logic             upd_taken;

    modport master (
        output pred_valid_in, pred_pc, history, upd_valid, upd_index, upd_taken,
        input  pred_valid_out, pred_taken, pred_index, ready
    );

    modport slave (
        input  pred_valid_in, pred_pc, history, upd_valid, upd_index, upd_taken,
        output pred_valid_out, pred_taken, pred_index, ready
    );
endinterface

// File: rtl/gshare_pht_sat_ctr2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_ctr2
    import gshare_pht_pkg::*;
(
    input  pht_ctr_t ctr,
    input  logic     taken,
    output pht_ctr_t next_ctr
);

    always_comb begin
        next_ctr = ctr;
        case (ctr)
            CTR_SNT: next_ctr = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: next_ctr = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  next_ctr = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  next_ctr = taken ? CTR_ST  : CTR_WT;
        endcase
    end

endmodule

// File: rtl/gshare_pht.sv
// Gshare direction predictor: PC/history-hashed table of 2-bit counters with
// a one-cycle prediction pipe, a single-cycle training RMW and a power-up init sweep.
module gshare_pht #(
    parameter int GHR_W       = gshare_pht_pkg::GHR_W,
    parameter int PHT_ENTRIES = gshare_pht_pkg::PHT_ENTRIES
) (
    input logic         clk,
    input logic         reset,
    gshare_pht_if.slave bus
);
    import gshare_pht_pkg::*;

    localparam logic [GHR_W-1:0] LAST_PTR = GHR_W'(PHT_ENTRIES - 1);

    pht_state_t       state;
    pht_state_t       state_next;
    logic             in_init;
    logic             ready_int;
    logic [GHR_W-1:0] sweep_ptr;

    pht_ctr_t         pht [PHT_ENTRIES];

    logic [GHR_W-1:0] pred_idx;
    pht_ctr_t         rd_ctr;
    pht_ctr_t         pred_ctr;
    pht_ctr_t         upd_ctr;
    pht_ctr_t         upd_next;
    logic             upd_en;
    logic             pred_en;

    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [GHR_W-1:0] pred_index_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:  if (sweep_ptr == LAST_PTR) state_next = READY;
            READY: state_next = READY;
        endcase
    end

    always_comb begin
        in_init   = 1'b0;
        ready_int = 1'b0;
        case (state)
            INIT:  in_init   = 1'b1;
            READY: ready_int = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_ptr <= '0;
        end else if (in_init) begin
            sweep_ptr <= sweep_ptr + 1'b1;
        end
    end

    assign pred_idx = bus.pred_pc[GHR_W+1:2] ^ bus.history;
    assign upd_en   = !in_init && bus.upd_valid;
    assign pred_en  = !in_init && bus.pred_valid_in;
    assign upd_ctr  = pht[bus.upd_index];
    assign rd_ctr   = pht[pred_idx];

    sat_ctr2 u_sat_ctr2 (
        .ctr      (upd_ctr),
        .taken    (bus.upd_taken),
        .next_ctr (upd_next)
    );

    // A training write landing on the entry being predicted is forwarded so the
    // prediction sees the counter as it will be after this edge.
    assign pred_ctr = (upd_en && (bus.upd_index == pred_idx)) ? upd_next : rd_ctr;

    always_ff @(posedge clk) begin
        if (in_init) begin
            pht[sweep_ptr] <= CTR_WNT;
        end else if (upd_en) begin
            pht[bus.upd_index] <= upd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            pred_valid_q <= pred_en;
            if (pred_en) begin
                pred_taken_q <= (pred_ctr >= CTR_WT);
                pred_index_q <= pred_idx;
            end
        end
    end

    assign bus.pred_valid_out = pred_valid_q;
    assign bus.pred_taken     = pred_taken_q;
    assign bus.pred_index     = pred_index_q;
    assign bus.ready          = ready_int;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed and model-checked bench for gshare_pht: init sweep timing, prediction
// pipe, saturation, bypass, reset restart and a short randomised stream.
module tb_gshare_pht;

    localparam int GHR_W = 10;
    localparam int N_ENT = 1024;

    logic clk;
    logic reset;

    gshare_pht_if #(.GHR_W(GHR_W)) bus ();

    gshare_pht #(.GHR_W(GHR_W), .PHT_ENTRIES(N_ENT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared;
    int n_mismatched;
    int model [N_ENT];

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic [9:0]  hist;
        logic        uv;
        logic [9:0]  uidx;
        logic        ut;
        logic        ev;
        logic        et;
        logic [9:0]  eidx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic pv, logic [31:0] pc, logic [9:0] hist,
                                 logic uv, logic [9:0] uidx, logic ut,
                                 logic ev, logic et, logic [9:0] eidx);
        vec_t v;
        v.pv = pv; v.pc = pc; v.hist = hist;
        v.uv = uv; v.uidx = uidx; v.ut = ut;
        v.ev = ev; v.et = et; v.eidx = eidx;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic [9:0] hist,
                                 input logic uv, input logic [9:0] uidx, input logic ut);
        bus.pred_valid_in = pv;
        bus.pred_pc       = pc;
        bus.history       = hist;
        bus.upd_valid     = uv;
        bus.upd_index     = uidx;
        bus.upd_taken     = ut;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic et, input logic [9:0] eidx);
        checkVal({name, ".valid"}, 32'(bus.pred_valid_out), 32'(ev));
        if (ev) begin
            checkVal({name, ".taken"}, 32'(bus.pred_taken), 32'(et));
            checkVal({name, ".index"}, 32'(bus.pred_index), 32'(eidx));
        end
    endtask

    // Walks one full init sweep from the first edge with reset low; ready must
    // rise only after the edge that writes the last entry.
    task automatic checkSweep(input string name);
        for (int i = 1; i <= N_ENT; i++) begin
            stepCycle();
            checkVal($sformatf("%s.ready[%0d]", name, i), 32'(bus.ready), 32'(i == N_ENT));
            checkVal($sformatf("%s.pvalid[%0d]", name, i), 32'(bus.pred_valid_out), 32'd0);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        applyStimulus(1'b0, 32'h0, 10'h0, 1'b0, 10'h0, 1'b0);

        repeat (3) stepCycle();
        checkVal("rst.ready", 32'(bus.ready), 32'd0);
        checkOutput("rst", 1'b0, 1'b0, 10'h0);
        checkVal("rst.taken", 32'(bus.pred_taken), 32'd0);
        checkVal("rst.index", 32'(bus.pred_index), 32'd0);

        // Requests during the sweep must be ignored, including training of 0x155.
        reset = 1'b0;
        applyStimulus(1'b1, 32'h554, 10'h0, 1'b1, 10'h155, 1'b1);
        checkSweep("sweep1");
        applyStimulus(1'b0, 32'h0, 10'h0, 1'b0, 10'h0, 1'b0);

        vecs.push_back(mkv(1, 32'h10,        10'h004, 0, 10'h000, 0, 1, 0, 10'h000));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 0, 10'h000, 0, 0, 0, 10'h000));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 1, 10'h155, 1, 0, 0, 10'h000));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 1, 10'h155, 1, 0, 0, 10'h000));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 1, 10'h155, 1, 0, 0, 10'h000));
        vecs.push_back(mkv(1, 32'h554,       10'h000, 0, 10'h000, 0, 1, 1, 10'h155));
        vecs.push_back(mkv(1, 32'h554,       10'h000, 1, 10'h155, 0, 1, 1, 10'h155));
        vecs.push_back(mkv(1, 32'h0,         10'h155, 1, 10'h155, 0, 1, 0, 10'h155));
        vecs.push_back(mkv(1, 32'h554,       10'h000, 0, 10'h000, 0, 1, 0, 10'h155));
        vecs.push_back(mkv(1, 32'h2A8,       10'h000, 1, 10'h0AA, 1, 1, 1, 10'h0AA));
        vecs.push_back(mkv(1, 32'h3FC,       10'h055, 0, 10'h000, 0, 1, 1, 10'h0AA));
        vecs.push_back(mkv(1, 32'h4,         10'h000, 1, 10'h0AA, 0, 1, 0, 10'h001));
        vecs.push_back(mkv(1, 32'h2A8,       10'h000, 0, 10'h000, 0, 1, 0, 10'h0AA));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 1, 10'h300, 1, 0, 0, 10'h000));
        vecs.push_back(mkv(1, 32'hFFFF_FC00, 10'h000, 1, 10'h300, 1, 1, 1, 10'h300));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 1, 10'h300, 0, 0, 0, 10'h000));
        vecs.push_back(mkv(1, 32'hFFFF_FC00, 10'h000, 1, 10'h300, 0, 1, 0, 10'h300));
        vecs.push_back(mkv(1, 32'h3FC,       10'h3FF, 0, 10'h000, 0, 1, 0, 10'h300));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 1, 10'h000, 0, 0, 0, 10'h000));
        vecs.push_back(mkv(0, 32'h0,         10'h000, 1, 10'h000, 0, 0, 0, 10'h000));
        vecs.push_back(mkv(1, 32'h10,        10'h004, 1, 10'h000, 1, 1, 0, 10'h000));
        vecs.push_back(mkv(1, 32'h10,        10'h004, 1, 10'h000, 1, 1, 1, 10'h000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pv, vecs[i].pc, vecs[i].hist, vecs[i].uv, vecs[i].uidx, vecs[i].ut);
            stepCycle();
            checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].et, vecs[i].eidx);
        end
        applyStimulus(1'b0, 32'h0, 10'h0, 1'b0, 10'h0, 1'b0);
        stepCycle();
        checkOutput("idle", 1'b0, 1'b0, 10'h0);

        // Train 0x123 strongly taken, then reset with a prediction in flight.
        applyStimulus(1'b0, 32'h0, 10'h0, 1'b1, 10'h123, 1'b1);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 32'h48C, 10'h0, 1'b0, 10'h0, 1'b0);
        stepCycle();
        checkOutput("pre_rst", 1'b1, 1'b1, 10'h123);
        reset = 1'b1;
        stepCycle();
        checkOutput("rst_ready", 1'b0, 1'b0, 10'h0);
        checkVal("rst_ready.taken", 32'(bus.pred_taken), 32'd0);
        checkVal("rst_ready.index", 32'(bus.pred_index), 32'd0);
        checkVal("rst_ready.ready", 32'(bus.ready), 32'd0);

        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 10'h0, 1'b0, 10'h0, 1'b0);
        for (int i = 1; i <= 500; i++) begin
            stepCycle();
            checkVal($sformatf("part.ready[%0d]", i), 32'(bus.ready), 32'd0);
        end
        reset = 1'b1;
        stepCycle();
        checkVal("mid_rst.ready", 32'(bus.ready), 32'd0);
        reset = 1'b0;
        checkSweep("sweep2");

        applyStimulus(1'b1, 32'h48C, 10'h0, 1'b0, 10'h0, 1'b0);
        stepCycle();
        checkOutput("post_rst", 1'b1, 1'b0, 10'h123);

        // Randomised stream against a behavioural counter model; indices are
        // drawn from a small pool so bypass and back-to-back cases occur often.
        for (int i = 0; i < N_ENT; i++) model[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            logic        pv, uv, ut, exp_t;
            logic [9:0]  hist, tgt, uidx, pidx;
            logic [31:0] rnd, pc;
            int          cur;
            pv   = 1'($urandom_range(0, 1));
            uv   = 1'($urandom_range(0, 1));
            ut   = 1'($urandom_range(0, 1));
            rnd  = $urandom;
            hist = rnd[9:0];
            tgt  = 10'($urandom_range(0, 7));
            uidx = 10'($urandom_range(0, 7));
            rnd  = $urandom;
            pc   = {rnd[31:12], tgt ^ hist, rnd[1:0]};
            pidx = tgt;
            if (uv) begin
                cur = model[uidx];
                cur = ut ? cur + 1 : cur - 1;
                if (cur > 3) cur = 3;
                if (cur < 0) cur = 0;
                model[uidx] = cur;
            end
            exp_t = (model[pidx] >= 2);
            applyStimulus(pv, pc, hist, uv, uidx, ut);
            stepCycle();
            checkOutput($sformatf("rand%0d", c), pv, exp_t, pidx);
        end
        applyStimulus(1'b0, 32'h0, 10'h0, 1'b0, 10'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
